// File: rtl/morse_pkg.sv
// morse_pkg: scan-code constants, Morse timing units, FSM state type and the
// scan-code (set 2 make code) to Morse pattern lookup shared by the keyer.
package morse_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int DASH_UNITS = 3;
  localparam int LGAP_UNITS = 3;
  localparam int WGAP_UNITS = 4;

  // Symbols are left-aligned: first symbol in sym[4], 1 = dash.
  // A space is a valid entry with len 0.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] sym;
  } morse_pat_t;

  typedef struct packed {
    logic       valid;
    morse_pat_t pat;
  } morse_lut_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MARK = 3'd2,
    S_GAP  = 3'd3,
    S_LGAP = 3'd4,
    S_WGAP = 3'd5
  } morse_state_t;

  function automatic morse_lut_t mk(input logic [2:0] len, input logic [4:0] sym);
    return {1'b1, len, sym};
  endfunction

  function automatic morse_lut_t scan_to_morse(input logic [7:0] code);
    morse_lut_t r;
    r = '0;
    case (code)
      8'h1C: r = mk(3'd2, 5'b01000); // A .-
      8'h32: r = mk(3'd4, 5'b10000); // B -...
      8'h21: r = mk(3'd4, 5'b10100); // C -.-.
      8'h23: r = mk(3'd3, 5'b10000); // D -..
      8'h24: r = mk(3'd1, 5'b00000); // E .
      8'h2B: r = mk(3'd4, 5'b00100); // F ..-.
      8'h34: r = mk(3'd3, 5'b11000); // G --.
      8'h33: r = mk(3'd4, 5'b00000); // H ....
      8'h43: r = mk(3'd2, 5'b00000); // I ..
      8'h3B: r = mk(3'd4, 5'b01110); // J .---
      8'h42: r = mk(3'd3, 5'b10100); // K -.-
      8'h4B: r = mk(3'd4, 5'b01000); // L .-..
      8'h3A: r = mk(3'd2, 5'b11000); // M --
      8'h31: r = mk(3'd2, 5'b10000); // N -.
      8'h44: r = mk(3'd3, 5'b11100); // O ---
      8'h4D: r = mk(3'd4, 5'b01100); // P .--.
      8'h15: r = mk(3'd4, 5'b11010); // Q --.-
      8'h2D: r = mk(3'd3, 5'b01000); // R .-.
      8'h1B: r = mk(3'd3, 5'b00000); // S ...
      8'h2C: r = mk(3'd1, 5'b10000); // T -
      8'h3C: r = mk(3'd3, 5'b00100); // U ..-
      8'h2A: r = mk(3'd4, 5'b00010); // V ...-
      8'h1D: r = mk(3'd3, 5'b01100); // W .--
      8'h22: r = mk(3'd4, 5'b10010); // X -..-
      8'h35: r = mk(3'd4, 5'b10110); // Y -.--
      8'h1A: r = mk(3'd4, 5'b11000); // Z --..
      8'h45: r = mk(3'd5, 5'b11111); // 0
      8'h16: r = mk(3'd5, 5'b01111); // 1
      8'h1E: r = mk(3'd5, 5'b00111); // 2
      8'h26: r = mk(3'd5, 5'b00011); // 3
      8'h25: r = mk(3'd5, 5'b00001); // 4
      8'h2E: r = mk(3'd5, 5'b00000); // 5
      8'h36: r = mk(3'd5, 5'b10000); // 6
      8'h3D: r = mk(3'd5, 5'b11000); // 7
      8'h3E: r = mk(3'd5, 5'b11100); // 8
      8'h46: r = mk(3'd5, 5'b11110); // 9
      8'h29: r = mk(3'd0, 5'b00000); // word space
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic scan_valid(input logic [7:0] code);
    morse_lut_t r;
    r = scan_to_morse(code);
    return r.valid;
  endfunction

endpackage

// File: rtl/morse_sync_fifo.sv
// morse_sync_fifo: single-clock FIFO with registered read data. A pop loads
// the head entry into o_dout, so the word is usable the cycle after the pop.
// Pushes while full are ignored (the caller reports the drop).
module morse_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_din,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_wr, w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_dout  = r_dout;
  assign o_count = r_count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyer_engine.sv
// morse_keyer_engine: filters PS/2 set-2 make codes, buffers them and keys
// ITU Morse timing on morse_code_out. Optional sidetone on tone_out is built
// only when MORSE_SIDETONE_EN is defined; otherwise tone_out is tied 0.
module morse_keyer_engine
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = 10_000_000,
  parameter int FIFO_DEPTH   = 16,
  parameter int TONE_DIV     = 5_000
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        ps2_received_data,
  input  logic                              ps2_received_data_strb,
  output logic                              morse_code_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              tone_out
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  // Sized for the longest element (word gap) so the counter never wraps.
  localparam int CNT_W = $clog2(WGAP_UNITS*CLK_PER_UNIT);
  localparam logic [CNT_W-1:0] T_DOT  = CNT_W'(CLK_PER_UNIT-1);
  localparam logic [CNT_W-1:0] T_DASH = CNT_W'(DASH_UNITS*CLK_PER_UNIT-1);
  localparam logic [CNT_W-1:0] T_LGAP = CNT_W'(LGAP_UNITS*CLK_PER_UNIT-1);
  localparam logic [CNT_W-1:0] T_WGAP = CNT_W'(WGAP_UNITS*CLK_PER_UNIT-1);

  if (CLK_PER_UNIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || TONE_DIV < 1) begin : g_param_check
    $error("morse_keyer_engine: illegal parameter set");
  end

  logic            r_brk, r_ext, r_ovf, r_key;
  morse_state_t    r_state, w_nstate;
  logic [CNT_W-1:0] r_cnt, w_target;
  logic            w_done;
  logic [4:0]      r_sym;
  logic [2:0]      r_len;
  logic            w_push, w_pop, w_full, w_empty;
  logic [7:0]      w_dout;
  logic [CW-1:0]   w_count;
  morse_lut_t      w_load_lut;

  // Prefix bytes arm a one-shot discard of the following byte.
  assign w_push = ps2_received_data_strb & ~r_brk & ~r_ext &
                  scan_valid(ps2_received_data);

  morse_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (ps2_received_data),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_load_lut = scan_to_morse(w_dout);

  // Break/extend prefix tracking and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brk <= 1'b0;
      r_ext <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_push & w_full;
      if (ps2_received_data_strb) begin
        if (r_brk | r_ext) begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else if (ps2_received_data == SC_BREAK) begin
          r_brk <= 1'b1;
        end else if (ps2_received_data == SC_EXT) begin
          r_ext <= 1'b1;
        end
      end
    end
  end

  // Terminal count for the element currently being timed.
  always_comb begin
    w_target = T_DOT;
    case (r_state)
      S_MARK:  w_target = r_sym[4] ? T_DASH : T_DOT;
      S_LGAP:  w_target = T_LGAP;
      S_WGAP:  w_target = T_WGAP;
      default: w_target = T_DOT;
    endcase
  end

  assign w_done = (r_cnt == w_target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state and FIFO pop decision.
  always_comb begin
    w_nstate = r_state;
    w_pop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_nstate = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_load_lut.valid)         w_nstate = S_IDLE;
        else if (w_dout == SC_SPACE)   w_nstate = S_WGAP;
        else                           w_nstate = S_MARK;
      end
      S_MARK: if (w_done) w_nstate = (r_len == 3'd1) ? S_LGAP : S_GAP;
      S_GAP:  if (w_done) w_nstate = S_MARK;
      S_LGAP: if (w_done) w_nstate = S_IDLE;
      S_WGAP: if (w_done) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Unit counter, symbol shifter and registered key output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sym <= '0;
      r_len <= '0;
      r_key <= 1'b0;
    end else begin
      r_key <= (w_nstate == S_MARK);
      if (w_nstate != r_state || r_state == S_IDLE) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + 1'b1;
      if (r_state == S_LOAD) begin
        r_sym <= w_load_lut.pat.sym;
        r_len <= w_load_lut.pat.len;
      end else if (r_state == S_MARK && w_done) begin
        r_sym <= {r_sym[3:0], 1'b0};
        r_len <= r_len - 1'b1;
      end
    end
  end

  assign morse_code_out = r_key;
  assign busy           = (r_state != S_IDLE);
  assign fifo_count     = w_count;
  assign overflow       = r_ovf;

`ifdef MORSE_SIDETONE_EN
  localparam int TW = $clog2(TONE_DIV+1);
  logic [TW-1:0] r_tdiv;
  logic          r_tone;

  // Square wave while keyed; divider held in reset whenever the key is up.
  always_ff @(posedge clk) begin
    if (rst || !r_key) begin
      r_tdiv <= '0;
      r_tone <= 1'b0;
    end else if (r_tdiv == TW'(TONE_DIV-1)) begin
      r_tdiv <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_tdiv <= r_tdiv + 1'b1;
    end
  end

  assign tone_out = r_tone & r_key;
`else
  assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_keyer_engine.sv
// Scoreboard bench for morse_keyer_engine: stimulus pushes expected mark/space
// runs derived from a dot/dash string table; a monitor measures key runs.
module tb_morse_keyer_engine;

  localparam int CPU   = 4;
  localparam int DEPTH = 4;
  localparam int TDIV  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       strb;
  logic       key, busy, ovf, tone;
  logic [2:0] cnt;

  always #5 clk = ~clk;

  morse_keyer_engine #(
    .CLK_PER_UNIT (CPU),
    .FIFO_DEPTH   (DEPTH),
    .TONE_DIV     (TDIV)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ps2_received_data      (data),
    .ps2_received_data_strb (strb),
    .morse_code_out         (key),
    .busy                   (busy),
    .fifo_count             (cnt),
    .overflow               (ovf),
    .tone_out               (tone)
  );

  typedef struct {
    int hi;
    int lo;
    bit exact;
  } exp_t;

  exp_t       sb[$];
  string      mt[bit [7:0]];
  bit [7:0]   codes[$];
  int checks = 0;
  int errors = 0;

  // model state
  bit skip = 0, had_letter = 0, chain_ok = 1;
  int pend_gap = 0, pend_pops = 0;

  // monitor statistics
  int peak = 0, ovf_hi = 0, tone_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s actual=%0d expected>=%0d", nm, act, lim);
    end
  endtask

  function automatic void add(input bit [7:0] c, input string s);
    mt[c] = s;
    codes.push_back(c);
  endfunction

  function automatic void init_table();
    add(8'h1C, ".-");    add(8'h32, "-...");  add(8'h21, "-.-.");
    add(8'h23, "-..");   add(8'h24, ".");     add(8'h2B, "..-.");
    add(8'h34, "--.");   add(8'h33, "....");  add(8'h43, "..");
    add(8'h3B, ".---");  add(8'h42, "-.-");   add(8'h4B, ".-..");
    add(8'h3A, "--");    add(8'h31, "-.");    add(8'h44, "---");
    add(8'h4D, ".--.");  add(8'h15, "--.-");  add(8'h2D, ".-.");
    add(8'h1B, "...");   add(8'h2C, "-");     add(8'h3C, "..-");
    add(8'h2A, "...-");  add(8'h1D, ".--");   add(8'h22, "-..-");
    add(8'h35, "-.--");  add(8'h1A, "--..");  add(8'h45, "-----");
    add(8'h16, ".----"); add(8'h1E, "..---"); add(8'h26, "...--");
    add(8'h25, "....-"); add(8'h2E, "....."); add(8'h36, "-....");
    add(8'h3D, "--..."); add(8'h3E, "---.."); add(8'h46, "----.");
  endfunction

  function automatic void model_reset();
    skip = 0; had_letter = 0; chain_ok = 1; pend_gap = 0; pend_pops = 0;
  endfunction

  // Drive one strobe and record what the key line must show for it.
  // link: this byte follows the previous one with no idle time in between.
  // acc:  the byte is expected to be stored (0 only for a known overflow).
  task automatic send(input bit [7:0] b, input bit link, input bit acc);
    string s;
    @(negedge clk);
    data = b;
    strb = 1'b1;
    if (skip) begin
      skip = 0;
    end else if (b == 8'hF0 || b == 8'hE0) begin
      skip = 1;
    end else if (acc && (b == 8'h29 || mt.exists(b))) begin
      chain_ok = chain_ok & link;
      pend_pops++;
      if (b == 8'h29) begin
        pend_gap += 4*CPU;
      end else begin
        s = mt[b];
        for (int i = 0; i < s.len(); i++) begin
          exp_t e;
          e.hi = (s[i] == "-") ? 3*CPU : CPU;
          if (i == 0) begin
            e.exact = had_letter && chain_ok;
            e.lo    = e.exact ? pend_gap + 2*pend_pops : pend_gap;
          end else begin
            e.exact = 1;
            e.lo    = CPU;
          end
          sb.push_back(e);
        end
        had_letter = 1; pend_gap = 3*CPU; pend_pops = 0; chain_ok = 1;
      end
    end
  endtask

  task automatic rel();
    @(negedge clk);
    strb = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (!busy && cnt == 0) begin ok = 1; break; end
    end
    chk(nm, int'(ok), 1);
  endtask

  // Monitor: measure each key-down run and the key-up run before it.
  initial begin
    bit prev = 0;
    int hi_run = 0, lo_run = 1000000, lo_at_rise = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev = 0; hi_run = 0; lo_run = 1000000;
      end else begin
        if (ovf) ovf_hi++;
        if (int'(cnt) > peak) peak = int'(cnt);
`ifdef MORSE_SIDETONE_EN
        if (tone && !key) tone_bad++;
`else
        if (tone) tone_bad++;
`endif
        if (key) begin
          if (!prev) lo_at_rise = lo_run;
          hi_run++;
        end else begin
          if (prev) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_mark len=%0d expected=none", hi_run);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("mark_len", hi_run, e.hi);
              if (e.exact) chk("space_len", lo_at_rise, e.lo);
              else         chk_ge("space_len_min", lo_at_rise, e.lo);
            end
            hi_run = 0; lo_run = 0;
          end
          lo_run++;
        end
        prev = key;
      end
    end
  end

  initial begin
    int lg, guard, hiseen;
    bit got;
    init_table();
    rst = 1'b1; strb = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key", int'(key), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_tone", int'(tone), 0);
    @(negedge clk); rst = 1'b0;

    // 'E': latency and trailing letter gap
    send(8'h24, 0, 1);
    @(posedge clk); #1;
    chk("e_count_n", int'(cnt), 1);
    @(negedge clk); strb = 1'b0;
    @(posedge clk); #1;
    chk("e_key_n1", int'(key), 0);
    chk("e_busy_n1", int'(busy), 1);
    @(posedge clk); #1;
    chk("e_key_n2", int'(key), 1);
    lg = 0; guard = 0;
    while ((key || busy) && guard < 200) begin
      if (!key && busy) lg++;
      @(posedge clk); #1;
      guard++;
    end
    chk("e_lgap", lg, 3*CPU);
    chk("e_busy_after", int'(busy), 0);

    // 'A': dot, gap, dash
    send(8'h1C, 0, 1);
    rel();
    wait_idle(300, "a_drain");

    // prefixed codes are swallowed
    peak = 0;
    send(8'hF0, 0, 1); send(8'h24, 0, 1);
    send(8'hE0, 0, 1); send(8'h1C, 0, 1);
    rel();
    hiseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (key || busy) hiseen++;
    end
    chk("prefix_key_busy", hiseen, 0);
    chk("prefix_count_peak", peak, 0);

    // T, space, T back to back
    send(8'h2C, 0, 1); send(8'h29, 1, 1); send(8'h2C, 1, 1);
    rel();
    wait_idle(600, "tst_drain");

    // overflow: six '0' strobes, FIFO of four
    peak = 0; ovf_hi = 0;
    send(8'h45, 0, 1);
    for (int i = 0; i < 4; i++) send(8'h45, 1, 1);
    send(8'h45, 1, 0);
    rel();
    wait_idle(3000, "ovf_drain");
    chk("ovf_peak", peak, DEPTH);
    chk("ovf_pulses", ovf_hi, 1);

    // reset in the middle of a dash, with another letter queued
    send(8'h2C, 0, 1); send(8'h24, 1, 1);
    rel();
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (key) begin got = 1; break; end
    end
    chk("rst_mid_key_seen", int'(got), 1);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    chk("rst_mid_key", int'(key), 0);
    chk("rst_mid_count", int'(cnt), 0);
    chk("rst_mid_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    send(8'h24, 0, 1);
    rel();
    wait_idle(300, "post_rst_drain");

    // random traffic, rate limited so the FIFO never overflows
    for (int n = 0; n < 40; n++) begin
      int r;
      bit [7:0] b;
      bit [7:0] unk[4];
      unk[0] = 8'h76; unk[1] = 8'h5A; unk[2] = 8'h12; unk[3] = 8'h05;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = unk[$urandom_range(0, 3)];
        3: b = 8'h29;
        default: b = codes[$urandom_range(0, codes.size()-1)];
      endcase
      got = 0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (cnt < DEPTH) begin got = 1; break; end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_gate_timeout count=%0d expected<%0d", cnt, DEPTH);
      end
      send(b, 0, 1);
      rel();
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_idle(20000, "rand_drain");
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("tone_rule", tone_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
